// File: rtl/core_pkg.sv
// Shared definitions for the core front end: opcode/func encodings,
// instruction field bit positions and the NOP word.
package core_pkg;

  typedef enum logic [1:0] {
    OP_ALU = 2'b00,
    OP_LDR = 2'b01,
    OP_STR = 2'b10,
    OP_B   = 2'b11
  } opcode_t;

  typedef enum logic [3:0] {
    F_ADD = 4'b0000,
    F_SUB = 4'b0001,
    F_AND = 4'b0010,
    F_ORR = 4'b0011,
    F_EOR = 4'b0100,
    F_MOV = 4'b0101,
    F_MVN = 4'b0110,
    F_LSL = 4'b0111,
    F_LSR = 4'b1000,
    F_CMP = 4'b1001
  } func_t;

  // Instruction field bit positions
  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 30;
  localparam int unsigned INMED_B  = 29;
  localparam int unsigned FUNC_HI  = 28;
  localparam int unsigned FUNC_LO  = 25;
  localparam int unsigned RD_HI    = 24;
  localparam int unsigned RD_LO    = 21;
  localparam int unsigned RN_HI    = 20;
  localparam int unsigned RN_LO    = 17;
  localparam int unsigned RM_HI    = 16;
  localparam int unsigned RM_LO    = 13;
  localparam int unsigned IMM_HI   = 16;
  localparam int unsigned BOFF_HI  = 24;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_decode_stage_hazard_detect.sv
// Load-use hazard detection: flags when the load in execute writes a
// register that the decode-stage instruction reads.
module hazard_detect
  import core_pkg::*;
#(
  parameter int unsigned RA_W = 4
) (
  input  logic [1:0]      op,
  input  logic            inmed,
  input  logic [RA_W-1:0] rd,
  input  logic [RA_W-1:0] rn,
  input  logic [RA_W-1:0] rm,
  input  logic            valid_d,
  input  logic            memtoreg_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic            valid_e,
  output logic            hz
);

  logic src_match;

  // Match rd_e against the registers this opcode actually reads
  always_comb begin
    src_match = 1'b0;
    case (op)
      OP_ALU, OP_LDR: src_match = (rd_e == rn) | (~inmed & (rd_e == rm));
      OP_STR:         src_match = (rd_e == rn) | (rd_e == rd);
      default:        src_match = 1'b0;
    endcase
    hz = valid_d & valid_e & memtoreg_e & src_match;
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Core front end: PC register, IF/ID pipeline register, field extraction,
// immediate generation and load-use stall control.
module fetch_decode_stage
  import core_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned RA_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_rdata,
  input  logic            stall_ext,
  input  logic            branch_taken_e,
  input  logic [PC_W-1:0] branch_target_e,
  input  logic            memtoreg_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic            valid_e,
  output logic [PC_W-1:0] pc_d,
  output logic            valid_d,
  output logic [1:0]      Op,
  output logic            Inmed,
  output logic [3:0]      func,
  output logic [RA_W-1:0] rd_d,
  output logic [RA_W-1:0] rn_d,
  output logic [RA_W-1:0] rm_d,
  output logic [PC_W-1:0] imm_d,
  output logic            bubble_e
);

  logic [PC_W-1:0] pc_f;
  logic [PC_W-1:0] instr_d;
  logic [PC_W-1:0] instr;
  logic [PC_W-1:0] redirect;
  logic            hz;

  assign imem_addr = pc_f;
  assign redirect  = branch_target_e & ~PC_W'(3);

  // PC and IF/ID register: redirect beats any stall, stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f    <= RESET_PC;
      instr_d <= PC_W'(NOP_WORD);
      pc_d    <= '0;
      valid_d <= 1'b0;
    end else if (branch_taken_e) begin
      pc_f    <= redirect;
      instr_d <= PC_W'(NOP_WORD);
      valid_d <= 1'b0;
    end else if (!(stall_ext | hz)) begin
      pc_f    <= pc_f + PC_W'(4);
      instr_d <= imem_rdata;
      pc_d    <= pc_f;
      valid_d <= 1'b1;
    end
  end

  // Empty decode slot decodes as all-zero fields
  always_comb begin
    instr = valid_d ? instr_d : PC_W'(NOP_WORD);
    Op    = instr[OP_HI:OP_LO];
    Inmed = instr[INMED_B];
    func  = instr[FUNC_HI:FUNC_LO];
    rd_d  = instr[RD_HI:RD_LO];
    rn_d  = instr[RN_HI:RN_LO];
    rm_d  = instr[RM_HI:RM_LO];
  end

  // Immediate: 17-bit signed for data ops, 25-bit word offset for branches
  always_comb begin
    imm_d = PC_W'($signed(instr[IMM_HI:0]));
    if (Op == OP_B)
      imm_d = PC_W'($signed({instr[BOFF_HI:0], 2'b00}));
  end

  hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard (
    .op        (Op),
    .inmed     (Inmed),
    .rd        (rd_d),
    .rn        (rn_d),
    .rm        (rm_d),
    .valid_d   (valid_d),
    .memtoreg_e(memtoreg_e),
    .rd_e      (rd_e),
    .valid_e   (valid_e),
    .hz        (hz)
  );

  // A taken branch flushes decode, so no bubble is needed behind it
  always_comb begin
    bubble_e = hz & ~branch_taken_e;
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_ext;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic        memtoreg_e;
  logic [3:0]  rd_e;
  logic        valid_e;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [1:0]  Op;
  logic        Inmed;
  logic [3:0]  func;
  logic [3:0]  rd_d;
  logic [3:0]  rn_d;
  logic [3:0]  rm_d;
  logic [31:0] imm_d;
  logic        bubble_e;

  logic [31:0] mem [0:255];
  int total;
  int bad;

  fetch_decode_stage #(
    .PC_W    (32),
    .RESET_PC(32'h0000_0000),
    .RA_W    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall_ext      (stall_ext),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .memtoreg_e     (memtoreg_e),
    .rd_e           (rd_e),
    .valid_e        (valid_e),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .Op             (Op),
    .Inmed          (Inmed),
    .func           (func),
    .rd_d           (rd_d),
    .rn_d           (rn_d),
    .rm_d           (rm_d),
    .imm_d          (imm_d),
    .bubble_e       (bubble_e)
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    valid_e    = 1'b0;
    memtoreg_e = 1'b0;
    rd_e       = 4'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0228_0000;  // ALU SUB rd=1 rn=4
    mem[1]   = 32'h1111_1111;
    mem[2]   = 32'h2222_2222;
    mem[3]   = 32'h3333_3333;
    mem[4]   = 32'h0046_A000;  // ADD rd=2 rn=3 rm=5
    mem[5]   = 32'h80C0_0000;  // STR rd=6 rn=0
    mem[64]  = 32'hC1FF_FFFF;  // B, offset all ones
    mem[255] = 32'h4000_0000;  // LDR

    rst             = 1'b1;
    stall_ext       = 1'b0;
    branch_taken_e  = 1'b0;
    branch_target_e = 32'h0;
    clear_e();

    step();
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_bubble", {31'd0, bubble_e}, 32'd0);
    rst = 1'b0;

    // free run
    step();
    chk("run0_pc", imem_addr, 32'd4);
    chk("run0_valid", {31'd0, valid_d}, 32'd1);
    chk("run0_pc_d", pc_d, 32'd0);
    chk("alu_op", {30'd0, Op}, 32'd0);
    chk("alu_func", {28'd0, func}, 32'd1);
    chk("alu_rd", {28'd0, rd_d}, 32'd1);
    chk("alu_rn", {28'd0, rn_d}, 32'd4);
    chk("alu_rm", {28'd0, rm_d}, 32'd0);
    chk("alu_imm", imm_d, 32'd0);
    step();
    chk("run1_pc", imem_addr, 32'd8);
    chk("run1_pc_d", pc_d, 32'd4);
    chk("run1_func", {28'd0, func}, 32'd8);
    chk("run1_imm", imm_d, 32'hFFFF_1111);
    step();
    chk("run2_pc", imem_addr, 32'd12);
    chk("run2_inmed", {31'd0, Inmed}, 32'd1);
    chk("run2_imm", imm_d, 32'h0000_2222);
    step();
    chk("run3_pc", imem_addr, 32'd16);
    step();
    chk("add_pc", imem_addr, 32'd20);
    chk("add_pc_d", pc_d, 32'd16);
    chk("add_rm", {28'd0, rm_d}, 32'd5);

    // load-use hazard checks on ADD rd=2 rn=3 rm=5
    valid_e = 1'b1; memtoreg_e = 1'b1;
    rd_e = 4'd2; #1;
    chk("hz_rd_not_src", {31'd0, bubble_e}, 32'd0);
    rd_e = 4'd5; #1;
    chk("hz_rm", {31'd0, bubble_e}, 32'd1);
    memtoreg_e = 1'b0; #1;
    chk("hz_not_load", {31'd0, bubble_e}, 32'd0);
    memtoreg_e = 1'b1; rd_e = 4'd3; #1;
    chk("hz_rn", {31'd0, bubble_e}, 32'd1);
    step();
    chk("hz_hold_pc", imem_addr, 32'd20);
    chk("hz_hold_pc_d", pc_d, 32'd16);
    chk("hz_hold_valid", {31'd0, valid_d}, 32'd1);
    clear_e(); #1;
    chk("hz_clear", {31'd0, bubble_e}, 32'd0);
    step();
    chk("adv_pc", imem_addr, 32'd24);
    chk("adv_pc_d", pc_d, 32'd20);
    chk("str_op", {30'd0, Op}, 32'd2);

    // store reads rd as data
    valid_e = 1'b1; memtoreg_e = 1'b1; rd_e = 4'd6; #1;
    chk("hz_str_rd", {31'd0, bubble_e}, 32'd1);
    rd_e = 4'd1; #1;
    chk("hz_str_none", {31'd0, bubble_e}, 32'd0);

    // branch with stall and hazard in the same cycle
    rd_e = 4'd6; stall_ext = 1'b1;
    branch_taken_e = 1'b1; branch_target_e = 32'h0000_0102; #1;
    chk("br_no_bubble", {31'd0, bubble_e}, 32'd0);
    step();
    chk("br_pc", imem_addr, 32'h0000_0100);
    chk("br_valid", {31'd0, valid_d}, 32'd0);
    chk("br_bubble", {31'd0, bubble_e}, 32'd0);
    chk("br_flush_op", {30'd0, Op}, 32'd0);
    branch_taken_e = 1'b0; stall_ext = 1'b0; clear_e();
    step();
    chk("b_pc", imem_addr, 32'h0000_0104);
    chk("b_pc_d", pc_d, 32'h0000_0100);
    chk("b_op", {30'd0, Op}, 32'd3);
    chk("b_imm", imm_d, 32'hFFFF_FFFC);
    valid_e = 1'b1; memtoreg_e = 1'b1; rd_e = 4'd15; #1;
    chk("hz_b_none", {31'd0, bubble_e}, 32'd0);
    clear_e();

    // external stall alone
    stall_ext = 1'b1;
    step();
    chk("st_pc", imem_addr, 32'h0000_0104);
    chk("st_pc_d", pc_d, 32'h0000_0100);
    chk("st_valid", {31'd0, valid_d}, 32'd1);

    // PC wrap
    stall_ext = 1'b0;
    branch_taken_e = 1'b1; branch_target_e = 32'hFFFF_FFFF;
    step();
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    branch_taken_e = 1'b0;
    step();
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_op", {30'd0, Op}, 32'd1);

    // async reset mid-stall
    stall_ext = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", imem_addr, 32'h0);
    chk("arst_pc_d", pc_d, 32'h0);
    chk("arst_valid", {31'd0, valid_d}, 32'd0);
    step();
    rst = 1'b0;
    stall_ext = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
